// File: rtl/ripemd160_right_line_if.sv
// Block-request / result bundle between a RIPEMD-160 driver and the right-line engine.
interface ripemd160_right_line_if;
  logic         start;
  logic [511:0] block_in;
  logic [159:0] h_in;
  logic         busy;
  logic         done;
  logic [159:0] right_out;

  modport master (output start, block_in, h_in, input busy, done, right_out);
  modport slave  (input start, block_in, h_in, output busy, done, right_out);
endinterface

// File: rtl/ripemd160_right_line.sv
// RIPEMD-160 right (parallel) line: 80 steps over one captured block,
// UNROLL steps per clock, final five-word state reported with a done pulse.
module ripemd160_right_line #(
  parameter int unsigned UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ripemd160_right_line_if.slave bus
);
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned NUM_STEPS = 80;
  localparam int unsigned J_W       = 7;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("ripemd160_right_line: UNROLL must be 1, 2 or 4");
  end

  localparam logic [3:0] R_TAB [NUM_STEPS] = '{
    4'd5,  4'd14, 4'd7,  4'd0,  4'd9,  4'd2,  4'd11, 4'd4,  4'd13, 4'd6,  4'd15, 4'd8,  4'd1,  4'd10, 4'd3,  4'd12,
    4'd6,  4'd11, 4'd3,  4'd7,  4'd0,  4'd13, 4'd5,  4'd10, 4'd14, 4'd15, 4'd8,  4'd12, 4'd4,  4'd9,  4'd1,  4'd2,
    4'd15, 4'd5,  4'd1,  4'd3,  4'd7,  4'd14, 4'd6,  4'd9,  4'd11, 4'd8,  4'd12, 4'd2,  4'd10, 4'd0,  4'd4,  4'd13,
    4'd8,  4'd6,  4'd4,  4'd1,  4'd3,  4'd11, 4'd15, 4'd0,  4'd5,  4'd12, 4'd2,  4'd13, 4'd9,  4'd7,  4'd10, 4'd14,
    4'd12, 4'd15, 4'd10, 4'd4,  4'd1,  4'd5,  4'd8,  4'd7,  4'd6,  4'd2,  4'd13, 4'd14, 4'd0,  4'd3,  4'd9,  4'd11
  };

  localparam logic [3:0] S_TAB [NUM_STEPS] = '{
    4'd8,  4'd9,  4'd9,  4'd11, 4'd13, 4'd15, 4'd15, 4'd5,  4'd7,  4'd7,  4'd8,  4'd11, 4'd14, 4'd14, 4'd12, 4'd6,
    4'd9,  4'd13, 4'd15, 4'd7,  4'd12, 4'd8,  4'd9,  4'd11, 4'd7,  4'd7,  4'd12, 4'd7,  4'd6,  4'd15, 4'd13, 4'd11,
    4'd9,  4'd7,  4'd15, 4'd11, 4'd8,  4'd6,  4'd6,  4'd14, 4'd12, 4'd13, 4'd5,  4'd14, 4'd13, 4'd13, 4'd7,  4'd5,
    4'd15, 4'd5,  4'd8,  4'd11, 4'd14, 4'd14, 4'd6,  4'd14, 4'd6,  4'd9,  4'd12, 4'd9,  4'd12, 4'd5,  4'd15, 4'd8,
    4'd8,  4'd5,  4'd12, 4'd9,  4'd12, 4'd5,  4'd14, 4'd6,  4'd8,  4'd13, 4'd6,  4'd5,  4'd15, 4'd13, 4'd11, 4'd11
  };

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input logic [3:0] n);
    logic [2*WORD_W-1:0] w;
    w = {v, v} << n;
    return w[2*WORD_W-1:WORD_W];
  endfunction

  // Right line walks the boolean functions in reverse order (F5 first).
  function automatic logic [WORD_W-1:0] f_of(input logic [J_W-1:0] idx,
                                              input logic [WORD_W-1:0] b, c, d);
    if (idx < J_W'(16))      return b ^ (c | ~d);
    else if (idx < J_W'(32)) return (b & d) | (c & ~d);
    else if (idx < J_W'(48)) return (b | ~c) ^ d;
    else if (idx < J_W'(64)) return (b & c) | (~b & d);
    else                     return b ^ c ^ d;
  endfunction

  function automatic logic [WORD_W-1:0] k_of(input logic [J_W-1:0] idx);
    if (idx < J_W'(16))      return 32'h50A28BE6;
    else if (idx < J_W'(32)) return 32'h5C4DD124;
    else if (idx < J_W'(48)) return 32'h6D703EF3;
    else if (idx < J_W'(64)) return 32'h7A6D76E9;
    else                     return 32'h00000000;
  endfunction

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [J_W-1:0]      j_q, j_d;
  logic [WORD_W-1:0]   a_q, b_q, c_q, d_q, e_q;
  logic [WORD_W-1:0]   a_d, b_d, c_d, d_d, e_d;
  logic [WORD_W-1:0]   x_q [NUM_WORDS];
  logic [WORD_W-1:0]   x_d [NUM_WORDS];
  logic                busy_q, busy_d, done_q, done_d;
  logic [159:0]        right_out_q, right_out_d;
  logic [WORD_W-1:0]   sa, sb, sc, sd, se, t;
  logic [J_W-1:0]      idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      x_q         <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      right_out_q <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      e_q         <= e_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      right_out_q <= right_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    e_d         = e_q;
    x_d         = x_q;
    done_d      = 1'b0;
    right_out_d = right_out_q;
    sa          = a_q;
    sb          = b_q;
    sc          = c_q;
    sd          = d_q;
    se          = e_q;
    t           = '0;
    idx         = '0;

    // UNROLL chained steps from the current counter value.
    for (int unsigned u = 0; u < UNROLL; u++) begin
      idx = j_q + J_W'(u);
      t   = rol(sa + f_of(idx, sb, sc, sd) + x_q[R_TAB[idx]] + k_of(idx), S_TAB[idx]) + se;
      sa  = se;
      se  = sd;
      sd  = rol(sc, 4'd10);
      sc  = sb;
      sb  = t;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          j_d     = '0;
          for (int i = 0; i < NUM_WORDS; i++) x_d[i] = bus.block_in[WORD_W*i +: WORD_W];
          {a_d, b_d, c_d, d_d, e_d} = bus.h_in;
        end
      end
      S_RUN: begin
        {a_d, b_d, c_d, d_d, e_d} = {sa, sb, sc, sd, se};
        // Counter parks on the last group so it never passes step 79.
        if (j_q == J_W'(NUM_STEPS - UNROLL)) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          right_out_d = {sa, sb, sc, sd, se};
        end else begin
          j_d = j_q + J_W'(UNROLL);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.right_out = right_out_q;
endmodule

// File: tb/tb_ripemd160_right_line.sv
// Randomized bench for the RIPEMD-160 right line at UNROLL 1, 2 and 4 against a step-loop model.
module tb_ripemd160_right_line;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ripemd160_right_line_if if1 ();
  ripemd160_right_line_if if2 ();
  ripemd160_right_line_if if4 ();

  ripemd160_right_line #(.UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  ripemd160_right_line #(.UNROLL(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  ripemd160_right_line #(.UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned rr [80] = '{
    5,14,7,0,9,2,11,4,13,6,15,8,1,10,3,12,
    6,11,3,7,0,13,5,10,14,15,8,12,4,9,1,2,
    15,5,1,3,7,14,6,9,11,8,12,2,10,0,4,13,
    8,6,4,1,3,11,15,0,5,12,2,13,9,7,10,14,
    12,15,10,4,1,5,8,7,6,2,13,14,0,3,9,11};
  int unsigned ss [80] = '{
    8,9,9,11,13,15,15,5,7,7,8,11,14,14,12,6,
    9,13,15,7,12,8,9,11,7,7,12,7,6,15,13,11,
    9,7,15,11,8,6,6,14,12,13,5,14,13,13,7,5,
    15,5,8,11,14,14,6,14,6,9,12,9,12,5,15,8,
    8,5,12,9,12,5,14,6,8,13,6,5,15,13,11,11};
  logic [31:0] kk [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000};

  function automatic logic [31:0] mrol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [159:0] model(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] x [16];
    logic [31:0] a, b, c, d, e, f, t;
    for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
    {a, b, c, d, e} = h;
    for (int j = 0; j < 80; j++) begin
      case (j / 16)
        0:       f = b ^ (c | ~d);
        1:       f = (b & d) | (c & ~d);
        2:       f = (b | ~c) ^ d;
        3:       f = (b & c) | (~b & d);
        default: f = b ^ c ^ d;
      endcase
      t = mrol(a + f + x[rr[j]] + kk[j / 16], int'(ss[j])) + e;
      a = e; e = d; d = mrol(c, 10); c = b; b = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [511:0] rnd_block();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [159:0] rnd_h();
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Presents one block to dut1; returns just after the accepting edge with inputs scrambled.
  task automatic issue1(input logic [159:0] h, input logic [511:0] blk);
    @(negedge clk);
    if1.h_in = h; if1.block_in = blk; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0; if1.h_in = rnd_h(); if1.block_in = rnd_block();
  endtask

  task automatic wait_done1(input int budget, output int n, output int busy_cnt);
    busy_cnt = (if1.busy === 1'b1) ? 1 : 0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin n = i; return; end
      if (if1.busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.start = 0; if2.start = 0; if4.start = 0;
    if1.block_in = '0; if2.block_in = '0; if4.block_in = '0;
    if1.h_in = '0; if2.h_in = '0; if4.h_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({if1.busy, if1.done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags1 got %b exp 00", {if1.busy, if1.done}); end
    n_cmp++; if (if1.right_out !== 160'd0) begin n_bad++; $display("FAIL reset_out1 got %h exp 0", if1.right_out); end
    n_cmp++; if ({if2.busy, if2.done, if4.busy, if4.done} !== 4'b0) begin n_bad++; $display("FAIL reset_flags24 got %b exp 0000", {if2.busy, if2.done, if4.busy, if4.done}); end
    rst = 1'b0;
  endtask

  task automatic test_golden();
    logic [159:0] h, exp;
    logic [511:0] blk;
    int n, bc;
    h = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    blk = '0; blk[31:0] = 32'h00000080;
    exp = model(h, blk);
    issue1(h, blk);
    wait_done1(100, n, bc);
    n_cmp++; if (n !== 80) begin n_bad++; $display("FAIL golden_latency got %0d exp 80", n); end
    n_cmp++; if (bc !== 80) begin n_bad++; $display("FAIL golden_busy_cycles got %0d exp 80", bc); end
    n_cmp++; if (if1.right_out !== exp) begin n_bad++; $display("FAIL golden_out got %h exp %h", if1.right_out, exp); end
    @(negedge clk);
    n_cmp++; if (if1.done !== 1'b0) begin n_bad++; $display("FAIL golden_done_pulse got %b exp 0", if1.done); end
  endtask

  task automatic test_unroll();
    logic [159:0] h, exp;
    logic [511:0] blk;
    int d2, d4, c2, c4;
    h = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    blk = '0; blk[31:0] = 32'h00000080;
    exp = model(h, blk);
    d2 = -1; d4 = -1; c2 = 0; c4 = 0;
    @(negedge clk);
    if2.h_in = h; if2.block_in = blk; if2.start = 1'b1;
    if4.h_in = h; if4.block_in = blk; if4.start = 1'b1;
    @(negedge clk);
    if2.start = 0; if4.start = 0; if2.block_in = rnd_block(); if4.h_in = rnd_h();
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (if2.done === 1'b1) begin c2++; if (d2 < 0) d2 = i; end
      if (if4.done === 1'b1) begin c4++; if (d4 < 0) d4 = i; end
    end
    n_cmp++; if (d2 !== 40 || c2 !== 1) begin n_bad++; $display("FAIL unroll2_done got cyc %0d cnt %0d exp 40/1", d2, c2); end
    n_cmp++; if (d4 !== 20 || c4 !== 1) begin n_bad++; $display("FAIL unroll4_done got cyc %0d cnt %0d exp 20/1", d4, c4); end
    n_cmp++; if (if2.right_out !== exp) begin n_bad++; $display("FAIL unroll2_out got %h exp %h", if2.right_out, exp); end
    n_cmp++; if (if4.right_out !== exp) begin n_bad++; $display("FAIL unroll4_out got %h exp %h", if4.right_out, exp); end
  endtask

  task automatic test_ignore_start();
    logic [159:0] h, exp;
    logic [511:0] blk;
    int dc, dcyc;
    h = rnd_h(); blk = rnd_block(); exp = model(h, blk);
    dc = 0; dcyc = -1;
    issue1(h, blk);
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin dc++; if (dcyc < 0) dcyc = i; end
      if (i == 5 || i == 40) begin
        if1.start = 1'b1; if1.block_in = rnd_block(); if1.h_in = rnd_h();
      end else begin
        if1.start = 1'b0;
      end
    end
    n_cmp++; if (dc !== 1 || dcyc !== 80) begin n_bad++; $display("FAIL ignore_done got cnt %0d cyc %0d exp 1/80", dc, dcyc); end
    n_cmp++; if (if1.right_out !== exp) begin n_bad++; $display("FAIL ignore_out got %h exp %h", if1.right_out, exp); end
  endtask

  task automatic test_back_to_back();
    logic [159:0] hs [3];
    logic [511:0] bs [3];
    logic [159:0] exp [3];
    logic [159:0] got [3];
    logic [159:0] held;
    int dcyc [3];
    int k, unstable;
    for (int i = 0; i < 3; i++) begin
      hs[i] = rnd_h(); bs[i] = rnd_block(); exp[i] = model(hs[i], bs[i]); dcyc[i] = -1; got[i] = '0;
    end
    k = 0; unstable = 0; held = '0;
    @(negedge clk);
    if1.start = 1'b1; if1.h_in = hs[0]; if1.block_in = bs[0];
    for (int c = 0; c < 300 && k < 3; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin
        dcyc[k] = c; got[k] = if1.right_out; held = if1.right_out; k++;
        if (k < 3) begin if1.h_in = hs[k]; if1.block_in = bs[k]; end
        else if1.start = 1'b0;
      end else if (k > 0 && if1.right_out !== held) begin
        unstable++;
      end
    end
    if1.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dcyc[i] !== 80 + 81*i) begin n_bad++; $display("FAIL b2b_done%0d got cyc %0d exp %0d", i, dcyc[i], 80 + 81*i); end
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL b2b_out%0d got %h exp %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL b2b_stable got %0d changes exp 0", unstable); end
  endtask

  task automatic test_reset_abort();
    logic [159:0] h, exp;
    logic [511:0] blk;
    int n, bc, dc;
    issue1(rnd_h(), rnd_block());
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({if1.busy, if1.done} !== 2'b00) begin n_bad++; $display("FAIL abort_flags got %b exp 00", {if1.busy, if1.done}); end
    n_cmp++; if (if1.right_out !== 160'd0) begin n_bad++; $display("FAIL abort_out got %h exp 0", if1.right_out); end
    dc = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (if1.done === 1'b1 || if1.busy === 1'b1) dc++;
    end
    n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL abort_quiet got %0d active cycles exp 0", dc); end
    h = rnd_h(); blk = rnd_block(); exp = model(h, blk);
    issue1(h, blk);
    wait_done1(100, n, bc);
    n_cmp++; if (n !== 80) begin n_bad++; $display("FAIL abort_restart_latency got %0d exp 80", n); end
    n_cmp++; if (if1.right_out !== exp) begin n_bad++; $display("FAIL abort_restart_out got %h exp %h", if1.right_out, exp); end
  endtask

  task automatic test_random();
    logic [159:0] h, exp;
    logic [511:0] blk;
    int n, bc;
    for (int r = 0; r < 3; r++) begin
      h = rnd_h(); blk = rnd_block(); exp = model(h, blk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue1(h, blk);
      wait_done1(100, n, bc);
      n_cmp++; if (n !== 80 || if1.right_out !== exp) begin
        n_bad++; $display("FAIL random%0d got cyc %0d out %h exp 80 %h", r, n, if1.right_out, exp);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_golden();
    test_unroll();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ripemd160_right_line.md
RIPEMD160_RIGHT_LINE -- requirements
Module: ripemd160_right_line

Interface
REQ-001 SHALL have parameter UNROLL, default 1: right-line steps per clock; legal values 1, 2, 4; any other value is a synthesis-time error.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to compress one block; sampled on rising clk.
REQ-005 SHALL have port block_in  input  512  message block; word X[j] = block_in[32*j+31:32*j], j=0..15, little-endian words as delivered by padding.
REQ-006 SHALL have port h_in  input  160  chaining value, packed A[159:128], B[127:96], C[95:64], D[63:32], E[31:0].
REQ-007 SHALL have port busy  output  1  high while steps are in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse; right_out valid.
REQ-009 SHALL have port right_out  output  160  final right-line state after 80 steps, same packing as h_in.

Function
REQ-010 SHALL accept start only when busy=0.
- On acceptance: capture block_in and h_in into internal registers, set step counter j=0, set busy=1.
- Inputs may change after the accepting edge.
REQ-011 SHALL ignore start while busy=1: no restart, no captured-input change.
REQ-012 SHALL perform UNROLL consecutive steps, j..j+UNROLL-1, on each clk edge with busy=1, then advance j by UNROLL.
REQ-013 SHALL compute each step, all additions mod 2^32, rol = rotate left:
- T = rol(A + f(B,C,D) + X[r'(j)] + K'(round), s'(j)) + E
- next state: A=E, B=T, C=B, D=rol(C,10), E=D.
REQ-014 SHALL use round = j/16 (0..4) with:
- f selected as F5, F4, F3, F2, F1 respectively, where F1=B^C^D, F2=(B&C)|(~B&D), F3=(B|~C)^D, F4=(B&D)|(C&~D), F5=B^(C|~D);
- K' = 50A28BE6, 5C4DD124, 6D703EF3, 7A6D76E9, 00000000 (hex).
REQ-015 SHALL implement the full 80-entry r' and s' right-line tables of the RIPEMD-160 specification as constant ROMs indexed by j.
- Round 0 r' = 5,14,7,0,9,2,11,4,13,6,15,8,1,10,3,12.
- Round 0 s' = 8,9,9,11,13,15,15,5,7,7,8,11,14,14,12,6.
REQ-016 SHALL, on the edge that completes step 79, clear busy, pulse done=1 for exactly one cycle, and load right_out with the final state.
- Latency: done is high 80/UNROLL cycles after the cycle in which start was accepted (80, 40 or 20).
REQ-017 SHALL hold right_out stable from the done pulse until the done pulse of the next block; right_out does not change during a later computation.
REQ-018 SHALL accept a start asserted in the same cycle done=1 (busy already 0), giving back-to-back throughput of one block per 80/UNROLL+1 cycles.
REQ-019 SHALL never let j exceed 79; the counter wraps to 0 only on a new acceptance.

Reset
REQ-020 SHALL, on any rising clk with rst=1, set busy=0, done=0, right_out=0, j=0, internal state=0; rst has priority over start.
REQ-021 SHALL abort an in-progress block on reset with no done pulse; the first start after rst deasserts is processed normally.

Verification
REQ-022 UNROLL=1, h_in = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0, block = padded empty message (X[0]=00000080, others 0), start 1 cycle -> busy high 80 cycles, done pulses exactly at cycle 80 after acceptance, right_out equals golden software right-line model.
REQ-023 Same stimulus with UNROLL=2 and UNROLL=4 -> identical right_out; done at cycle 40 and 20 respectively.
REQ-024 start re-pulsed at cycles 5 and 40 with different block_in -> ignored; result matches first block only; single done.
REQ-025 start held high continuously over 3 random blocks -> blocks accepted at cycles 0, 81, 162 (UNROLL=1); three done pulses; each right_out matches model and stays stable between pulses.
REQ-026 rst asserted at cycle 30 of a computation -> next edge busy=0, done=0, right_out=0, no done pulse; a new start then completes in 80 cycles with correct result.
